// File: rtl/mdu_sequencer.sv
// Iterative radix-2 multiply / restoring divide unit that owns the HI/LO registers.
// Optional MDU_EARLY_OUT_EN: early multiply exit and single-step divide-by-zero.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // state | meaning
  // IDLE  | HI/LO visible and writable by mthi/mtlo, waiting for start
  // CALC  | one multiply or divide iteration per edge
  // FIX   | sign correction and HI/LO write-back, done raised next cycle
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_op;
  logic [XLEN-1:0]       r_opnd, r_raw_a, r_hi, r_lo;
  logic [2*XLEN-1:0]     r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_neg_q, r_neg_r, r_dbz, r_done;

  logic                  w_sign_a, w_sign_b, w_b_zero, w_last;
  logic [XLEN-1:0]       w_mag_a, w_mag_b, w_quo, w_rem;
  logic [XLEN:0]         w_add, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]     w_mul_step, w_div_step, w_prod, w_acc_fast;
  logic                  w_early, w_dbz_fast;

  // op[0]=0 selects the signed variants
  assign w_sign_a = ~op[0] & operand_a[XLEN-1];
  assign w_sign_b = ~op[0] & operand_b[XLEN-1];
  assign w_mag_a  = w_sign_a ? -operand_a : operand_a;
  assign w_mag_b  = w_sign_b ? -operand_b : operand_b;
  assign w_b_zero = (operand_b == '0);
  assign w_last   = (r_cnt == '1);

  // Multiply: product grows into the upper half while the multiplier drains from the lower half
  assign w_add      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
  assign w_mul_step = r_acc[0] ? {w_add, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_step = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

`ifdef MDU_EARLY_OUT_EN
  logic [XLEN-1:0]  w_mpl_left;
  logic [CNT_W:0]   w_steps_left;
  // Remaining multiplier bits sit in the low XLEN-r_cnt bits; once zero only shifts remain
  assign w_mpl_left   = r_acc[XLEN-1:0] & ({XLEN{1'b1}} >> r_cnt);
  assign w_steps_left = (CNT_W+1)'(XLEN) - {1'b0, r_cnt};
  assign w_early      = ~r_op[1] & (w_mpl_left == '0);
  assign w_acc_fast   = r_acc >> w_steps_left;
  assign w_dbz_fast   = 1'b1;
`else
  assign w_early      = 1'b0;
  assign w_acc_fast   = r_acc;
  assign w_dbz_fast   = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (w_dbz_fast && op[1] && w_b_zero) ? S_FIX : S_CALC;
      S_CALC: if (w_last || w_early) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= '0;
      r_opnd  <= '0;
      r_raw_a <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_opnd  <= op[1] ? w_mag_b : w_mag_a;
            r_acc   <= {{XLEN{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
            r_raw_a <= operand_a;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_dbz   <= op[1] & w_b_zero;
            r_cnt   <= '0;
          end else begin
            if (mthi) r_hi <= operand_a;
            if (mtlo) r_lo <= operand_a;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_early)    r_acc <= w_acc_fast;
          else if (r_op[1]) r_acc <= w_div_step;
          else              r_acc <= w_mul_step;
        end
        S_FIX: begin
          if (r_dbz) begin
            r_lo <= '1;
            r_hi <= r_raw_a;
          end else if (!r_op[1]) begin
            {r_hi, r_lo} <= w_prod;
          end else begin
            r_lo <= w_quo;
            r_hi <= w_rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_mdu_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0, operand_b = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  mdu_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          total = 0, bad = 0, cyc = 0, n_done = 0;
  logic [31:0] cur_hi = '0, cur_lo = '0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural operations
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin sp = sa * sb; up = sp; rh = up[63:32]; rl = up[31:0]; end
      2'b01: begin up = {32'h0, a} * {32'h0, b}; rh = up[63:32]; rl = up[31:0]; end
      2'b10: begin
        if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
        else begin
          sq = sa / sb; sr = sa % sb;
          up = sq; rl = up[31:0];
          up = sr; rh = up[31:0];
        end
      end
      default: begin
        if (b == 0) begin rl = 32'hFFFF_FFFF; rh = a; end
        else begin rl = a / b; rh = a % b; end
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (reset_n && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = q.pop_front();
        chk("result_hi", 64'(hi), 64'(e.hi));
        chk("result_lo", 64'(lo), 64'(e.lo));
        if (e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(e.cyc));
        cur_hi = e.hi;
        cur_lo = e.lo;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) @(negedge clock);
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
    chk("drain_timeout", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic with_mthi);
    exp_t e;
    wait_idle();
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b; mthi = with_mthi;
    model(o, a, b, e.hi, e.lo);
`ifdef MDU_EARLY_OUT_EN
    e.cyc = -1;
`else
    e.cyc = cyc + 34;
`endif
    q.push_back(e);
    @(negedge clock);
    start = 1'b0; mthi = 1'b0;
    chk("busy_after_e0", 64'(busy), 64'(1));
  endtask

  task automatic mtx(input logic wh, input logic wl, input logic [31:0] v);
    wait_idle();
    @(negedge clock);
    mthi = wh; mtlo = wl; operand_a = v;
    if (wh) cur_hi = v;
    if (wl) cur_lo = v;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_hi", 64'(hi), 64'(cur_hi));
    chk("mt_lo", 64'(lo), 64'(cur_lo));
  endtask

  initial begin
    int d_before;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #12;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_busy", 64'(busy), 64'(0));

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'b11, 32'd7, 32'd2, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b11, 32'd5, 32'd0, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    mtx(1'b1, 1'b0, 32'h1234);
    mtx(1'b0, 1'b1, 32'h5678);
    mtx(1'b1, 1'b1, 32'h9ABC);

    // start together with mthi: start wins, write dropped
    issue(2'b01, 32'd3, 32'd4, 1'b1);
    chk("start_beats_mthi", 64'(hi), 64'(cur_hi));
    drain();

    // second start and mtlo/mthi during busy are ignored
    issue(2'b01, 32'h10, 32'h20, 1'b0);
    @(negedge clock);
    start = 1'b1; op = 2'b10; operand_a = 32'd100; operand_b = 32'd3; mtlo = 1'b1; mthi = 1'b1;
    @(negedge clock);
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    chk("busy_mt_lo", 64'(lo), 64'(cur_lo));
    chk("busy_mt_hi", 64'(hi), 64'(cur_hi));
    drain();
    repeat (40) @(negedge clock);

    // reset mid-CALC aborts without a done pulse
    issue(2'b11, 32'hDEAD_BEEF, 32'd9, 1'b0);
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    q.delete();
    cur_hi = '0; cur_lo = '0;
    d_before = n_done;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_no_done", 64'(n_done), 64'(d_before));
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    drain();

    for (int k = 0; k < 25; k++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       ra = 32'h8000_0000;
        1, 2:    ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1, 2, 3: rb = $urandom_range(1, 20);
        4:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        drain();
        mtx(1'($urandom_range(0, 1)), 1'b1, $urandom);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the single-cycle ALU in the execute stage.
- Accepts mult/multu/div/divu from decode.
- Runs a radix-2 iterative shift-add multiply or restoring divide.
- Drives a busy stall to the CPU control unit.
- Owns the architectural HI/LO state used by mfhi/mflo/mthi/mtlo.

Parameters:
- XLEN, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  issue request; sampled only in IDLE.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- operand_a  input  XLEN  rs value; multiplicand or dividend.
- operand_b  input  XLEN  rt value; multiplier or divisor.
- mthi  input  1  write operand_a to HI.
- mtlo  input  1  write operand_a to LO.
- busy  output  1  operation in flight; CPU must stall mfhi/mflo/mthi/mtlo/start.
- done  output  1  one-cycle pulse: HI/LO just updated by an operation.
- hi  output  XLEN  HI register.
- lo  output  XLEN  LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; hi=0, lo=0, done=0, busy=0; internal counter/operand registers cleared. Reset mid-operation aborts it: HI/LO are zeroed, and no done pulse follows.
- States and transitions:
  - IDLE -> CALC on a clock edge with start=1.
  - CALC -> FIX after 32 CALC edges (counter 0..31).
  - FIX -> IDLE on the next edge.
- busy = (state != IDLE), combinational from the state register.
- Issue (edge E0, start=1 in IDLE):
  - Latch op, |operand_a| and |operand_b|. Magnitudes are taken only for signed ops; unsigned ops use operands raw.
  - Latch the result sign: quotient/product sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Latch the raw operand_a and a divide-by-zero flag (operand_b==0, div ops only).
- CALC: one iteration per edge.
  - Multiply: 64-bit accumulator shift-add, LSB of the multiplier first.
  - Divide: restoring, one quotient bit per edge, MSB first.
- FIX edge (E33):
  - Apply two's-complement sign correction.
  - Multiply: {hi,lo} = 64-bit product.
  - Divide: lo = quotient, hi = remainder.
  - Register done=1 for exactly the cycle following E33.
- Latency: start edge E0 -> hi/lo valid and done=1 after edge E33; busy=1 from after E0 through E33.
- Divide by zero (div or divu): lo=0xFFFFFFFF, hi=raw operand_a. Sign correction is bypassed.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, with no exception.
- Gating while busy:
  - start is ignored; the latched op is unaffected.
  - mthi/mtlo are dropped; HI/LO are unchanged until FIX.
- In IDLE, mthi/mtlo update on the clock edge.
  - mthi and mtlo together write both registers.
  - start together with mthi/mtlo: start wins and the writes are dropped.
- hi/lo are driven directly from registers and never change except at FIX, on an IDLE mthi/mtlo edge, or at reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply leaves CALC for FIX on the edge where the remaining unshifted multiplier magnitude is 0. The accumulator is shifted by the remaining count so the result is unchanged.
  - Divide by zero goes IDLE -> FIX directly, so done follows edge E1.
  - Divide is always the full 32 iterations.
- Undefined: every operation takes exactly 32 CALC edges. Results are identical either way; only latency differs.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done high exactly in the cycle after E33 (macro off); busy low before E0.
- mult 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MDU_EARLY_OUT_EN, done arrives before E33 and hi/lo are identical.
- div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7 / 2 -> lo=3, hi=1; div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu 5 / 0 -> lo=0xFFFFFFFF, hi=5; div 0xFFFFFFF9 / 0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF9.
- mthi 0x1234 in IDLE -> hi=0x1234 next edge; mtlo and a second start during busy -> ignored; final hi/lo match the first op only.
- reset_n pulsed low mid-CALC -> hi=lo=0 immediately, busy=0, no done; a new start afterwards completes normally.
